pipe_mem: RTL

- Memory-access stage of the 5-stage pipeline, directly upstream of the write-back stage.
- Holds the EX/MEM pipeline register and a word-organised synchronous-write data memory supporting byte, halfword and word accesses.
- Drives the MEM-side write-back signals: write enable, load select, destination register, ALU result and extended load data.
- Flags misaligned accesses and squashes their side effects.

---
 rtl/pipe_mem.sv | 123 ++++++++++++
 1 files changed

// File: rtl/pipe_mem.sv
// Memory-access pipeline stage: EX/MEM register plus a byte-addressable,
// little-endian data memory with synchronous write and combinational read.
module pipe_mem #(
    parameter int ADDR_W = 10
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        EXwreg,
    input  logic        EXm2reg,
    input  logic        EXwmem,
    input  logic [1:0]  EXmsize,
    input  logic        EXmsign,
    input  logic [4:0]  EXwn,
    input  logic [31:0] EXaluResult,
    input  logic [31:0] EXstoreData,
    output logic        MEMwreg,
    output logic        MEMm2reg,
    output logic [4:0]  MEMwn,
    output logic [31:0] MEMaluResult,
    output logic [31:0] MEMmemOut,
    output logic        MEMmisalign
);

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;

    logic        wreg_q;
    logic        m2reg_q;
    logic        wmem_q;
    logic [1:0]  msize_q;
    logic        msign_q;
    logic [4:0]  wn_q;
    logic [31:0] alu_q;
    logic [31:0] sdata_q;

    logic [31:0] mem [0:(1<<ADDR_W)-1];

    logic [ADDR_W-1:0] idx;
    logic [1:0]        lane;
    logic [31:0]       rd_word;
    logic [7:0]        rd_byte;
    logic [15:0]       rd_half;
    logic              misalign;
    logic [3:0]        byte_en;
    logic [31:0]       wdata;

    // A cleared register is a bubble: no write, no load, no misalign.
    always_ff @(posedge clk) begin
        if (clr) begin
            wreg_q  <= 1'b0;
            m2reg_q <= 1'b0;
            wmem_q  <= 1'b0;
            msize_q <= 2'b00;
            msign_q <= 1'b0;
            wn_q    <= 5'd0;
            alu_q   <= 32'd0;
            sdata_q <= 32'd0;
        end else begin
            wreg_q  <= EXwreg;
            m2reg_q <= EXm2reg;
            wmem_q  <= EXwmem;
            msize_q <= EXmsize;
            msign_q <= EXmsign;
            wn_q    <= EXwn;
            alu_q   <= EXaluResult;
            sdata_q <= EXstoreData;
        end
    end

    assign idx  = alu_q[ADDR_W+1:2];
    assign lane = alu_q[1:0];

    always_comb begin
        misalign = 1'b0;
        byte_en  = 4'b1111;
        wdata    = sdata_q;
        case (msize_q)
            SZ_BYTE: begin
                byte_en = 4'b0001 << lane;
                wdata   = {4{sdata_q[7:0]}};
            end
            SZ_HALF: begin
                misalign = lane[0];
                byte_en  = lane[1] ? 4'b1100 : 4'b0011;
                wdata    = {2{sdata_q[15:0]}};
            end
            default: misalign = (lane != 2'b00);
        endcase
        misalign = misalign & (wmem_q | m2reg_q);
    end

    always_comb begin
        rd_word = mem[idx];
        rd_half = lane[1] ? rd_word[31:16] : rd_word[15:0];
        case (lane)
            2'd0:    rd_byte = rd_word[7:0];
            2'd1:    rd_byte = rd_word[15:8];
            2'd2:    rd_byte = rd_word[23:16];
            default: rd_byte = rd_word[31:24];
        endcase
        case (msize_q)
            SZ_BYTE: MEMmemOut = {{24{msign_q & rd_byte[7]}}, rd_byte};
            SZ_HALF: MEMmemOut = {{16{msign_q & rd_half[15]}}, rd_half};
            default: MEMmemOut = rd_word;
        endcase
    end

    // Gating by clr lets a reset on the store's edge cancel it.
    always_ff @(posedge clk) begin
        if (!clr && wmem_q && !misalign) begin
            for (int k = 0; k < 4; k++) begin
                if (byte_en[k]) mem[idx][8*k +: 8] <= wdata[8*k +: 8];
            end
        end
    end

    assign MEMwreg      = wreg_q & ~misalign;
    assign MEMm2reg     = m2reg_q;
    assign MEMwn        = wn_q;
    assign MEMaluResult = alu_q;
    assign MEMmisalign  = misalign;

endmodule
